// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: shares one single-ported memory between fetch and data ports, data-first with fetch starvation guard
module unified_memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic [DATA_WIDTH-1:0] instr_rdata,
  output logic                  instr_valid,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT - 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_n;
  logic owner_i, we_q, data_win, start, done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0] streak;
  always_comb begin
    start = state == IDLE && (instr_req || data_req);
    done = state == RESP && mem_rvalid;
    data_win = data_req && !(instr_req && streak == SMAX);
    state_n = start ? REQ : (state == REQ && mem_gnt) ? RESP : done ? IDLE : state;
    mem_req = state == REQ;
    mem_we = mem_req && we_q;
    instr_valid = done && owner_i;
    data_valid = done && !owner_i;
    instr_rdata = instr_valid ? mem_rdata : '0;
    data_rdata = data_valid ? mem_rdata : '0;
    busy = state != IDLE;
  end
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner_i <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      streak <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        owner_i <= !data_win;
        we_q <= data_win && data_we;
        addr_q <= data_win ? data_addr : instr_addr;
        wdata_q <= data_win ? data_wdata : '0;
        streak <= !(data_win && instr_req) ? '0 : streak == SMAX ? streak : streak + 1'b1;
      end
    end
  end
endmodule
